// File: rtl/rssi_monitor_if.sv
// rssi_monitor_if: handshake and data bundle between rssi_monitor and the serial RSSI converter
// Ports (master = monitor side): en/shdn start request and shutdown qualifier out;
// rdy (converter idle), data_rdy (sample valid) and data (8-bit sample) in.
interface rssi_monitor_if;
  logic       en;
  logic       shdn;
  logic       rdy;
  logic       data_rdy;
  logic [7:0] data;
  modport master (output en, shdn, input rdy, data_rdy, data);
  modport slave (input en, shdn, output rdy, data_rdy, data);
endinterface

// File: rtl/rssi_monitor.sv
// rssi_monitor: paces the RSSI converter, averages 2^LOG2N-sample windows, tracks peak and carrier sense
// Ports: clk, resetn (sync, active-low); run_i/sleep_i conversion and power-down levels;
// clear_peak_i pulse; thr_hi_i/thr_lo_i carrier-sense thresholds; adc converter bundle (master);
// avg_o/avg_valid_o window average and strobe; peak_o; cs_busy_o; timeout_err_o (sticky).
module rssi_monitor #(
  parameter int LOG2N = 3,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       run_i,
  input  logic       sleep_i,
  input  logic       clear_peak_i,
  input  logic [7:0] thr_hi_i,
  input  logic [7:0] thr_lo_i,
  rssi_monitor_if.master adc,
  output logic [7:0] avg_o,
  output logic       avg_valid_o,
  output logic [7:0] peak_o,
  output logic       cs_busy_o,
  output logic       timeout_err_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, SLP_REQ, PD} state_t;
  localparam int AW = 8 + LOG2N;
  localparam int WW = $clog2(TIMEOUT) + 1;
  state_t state_q, state_d;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [7:0] avg_q, avg_d, peak_q, peak_d, new_avg;
  logic rdy_prev_q, rise, sample, expire, full;
  logic en_q, en_d, shdn_q, shdn_d;
  logic avg_valid_q, avg_valid_d, cs_q, cs_d, err_q, err_d;
  assign rise = adc.data_rdy & ~rdy_prev_q;
  assign sample = state_q == WAIT && rise;
  // watchdog starts at 0 in REQ, so expiry lands TIMEOUT cycles after the start request
  assign expire = state_q == WAIT && !rise && wd_q == WW'(TIMEOUT - 1);
  assign sum = acc_q + AW'(adc.data);
  assign new_avg = sum[AW-1:LOG2N];
  assign full = &cnt_q;
  always_ff @(posedge clk)
    state_q <= !resetn ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !adc.rdy ? IDLE : sleep_i ? SLP_REQ : run_i ? REQ : IDLE;
      REQ:     state_d = WAIT;
      WAIT:    state_d = (sample || expire) ? IDLE : WAIT;
      SLP_REQ: state_d = PD;
      PD:      state_d = sleep_i ? PD : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // converter strobes are registered from the next state so they line up with REQ/SLP_REQ/PD
  always_comb begin
    en_d = state_d == REQ || state_d == SLP_REQ;
    shdn_d = state_d == SLP_REQ || state_d == PD;
  end
  always_comb begin
    acc_d = (state_q == IDLE && !run_i && !sleep_i) ? '0 : acc_q;
    cnt_d = (state_q == IDLE && !run_i && !sleep_i) ? '0 : cnt_q;
    wd_d = state_q == IDLE ? '0 : wd_q + WW'(1);
    avg_d = avg_q;
    avg_valid_d = 1'b0;
    cs_d = cs_q;
    err_d = err_q | expire;
    peak_d = clear_peak_i ? 8'd0 : peak_q;
    if (sample) begin
      peak_d = (clear_peak_i || adc.data > peak_q) ? adc.data : peak_q;
      acc_d = full ? '0 : sum;
      cnt_d = cnt_q + LOG2N'(1);
      if (full) begin
        avg_d = new_avg;
        avg_valid_d = 1'b1;
        cs_d = new_avg >= thr_hi_i ? 1'b1 : new_avg < thr_lo_i ? 1'b0 : cs_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_q <= '0;
      cnt_q <= '0;
      wd_q <= '0;
      rdy_prev_q <= 1'b1;
      en_q <= 1'b0;
      shdn_q <= 1'b0;
      avg_q <= 8'd0;
      avg_valid_q <= 1'b0;
      peak_q <= 8'd0;
      cs_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      wd_q <= wd_d;
      rdy_prev_q <= adc.data_rdy;
      en_q <= en_d;
      shdn_q <= shdn_d;
      avg_q <= avg_d;
      avg_valid_q <= avg_valid_d;
      peak_q <= peak_d;
      cs_q <= cs_d;
      err_q <= err_d;
    end
  end
  assign adc.en = en_q;
  assign adc.shdn = shdn_q;
  assign avg_o = avg_q;
  assign avg_valid_o = avg_valid_q;
  assign peak_o = peak_q;
  assign cs_busy_o = cs_q;
  assign timeout_err_o = err_q;
endmodule
